mirage_bus_arbiter: RTL

- Shares the single-port-per-direction system RAM and the two 8-bit output ports between two bus masters: CPU (master 0) and DMA/loader (master 1).
- Arbitrates round-robin, issues one access per cycle and routes synchronous read data back to the issuing master.
- Owns the memory-mapped output-port registers at 0x0200/0x0201.
- Sits between the RISC16 core, a secondary master and the RAM_1R_1W instance at SoC top level.

---
 rtl/mirage_bus_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mirage_bus_arbiter.sv
// Two-master round-robin arbiter in front of a 1R1W system RAM and two 8-bit
// memory-mapped output ports; read data returns exactly one cycle after grant.
module mirage_bus_arbiter #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] PORTA_ADDR     = 16'h0200,
  parameter logic [ADDR_WIDTH-1:0] PORTB_ADDR     = 16'h0201
) (
  input  logic                      aClock,
  input  logic                      aReset,
  input  logic                      aReq0,
  input  logic                      aReq1,
  input  logic [ADDR_WIDTH-1:0]     aAddress0,
  input  logic [ADDR_WIDTH-1:0]     aAddress1,
  input  logic                      aWrite0,
  input  logic                      aWrite1,
  input  logic [DATA_WIDTH-1:0]     aWriteData0,
  input  logic [DATA_WIDTH-1:0]     aWriteData1,
  output logic                      anOutGrant0,
  output logic                      anOutGrant1,
  output logic                      anOutReadValid0,
  output logic                      anOutReadValid1,
  output logic [DATA_WIDTH-1:0]     anOutReadData,
  output logic [MEM_ADDR_WIDTH-1:0] anOutMemAddress,
  output logic [DATA_WIDTH-1:0]     anOutMemWriteData,
  output logic                      anOutMemWrite,
  output logic                      anOutMemRead,
  input  logic [DATA_WIDTH-1:0]     aMemReadData,
  output logic [7:0]                anOutPortA,
  output logic [7:0]                anOutPortB
);

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_IO   = 2'd1,
    SRC_ZERO = 2'd2
  } read_src_e;

  logic                  ptr_q, ptr_d;
  logic                  grant0, grant1, any_grant, win_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  hit_porta, hit_portb, hit_io, hit_ram;

  logic [7:0]            port_a_q, port_a_d;
  logic [7:0]            port_b_q, port_b_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  read_src_e             pend_src_q, pend_src_d;
  logic [7:0]            pend_io_q, pend_io_d;

  // Pointer value names the master that wins when both request.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (aReq0 && aReq1) begin
      grant0 = !ptr_q;
      grant1 = ptr_q;
    end else begin
      grant0 = aReq0;
      grant1 = aReq1;
    end
    any_grant = grant0 | grant1;
    win_id    = grant1;
    ptr_d     = any_grant ? !win_id : ptr_q;
  end

  // With no grant the master-0 request fields pass through as don't-cares.
  always_comb begin
    sel_addr  = win_id ? aAddress1   : aAddress0;
    sel_write = win_id ? aWrite1     : aWrite0;
    sel_wdata = win_id ? aWriteData1 : aWriteData0;
    hit_porta = (sel_addr == PORTA_ADDR);
    hit_portb = (sel_addr == PORTB_ADDR);
    hit_io    = hit_porta | hit_portb;
    hit_ram   = !hit_io && ((sel_addr >> MEM_ADDR_WIDTH) == '0);
  end

  always_comb begin
    anOutGrant0       = grant0;
    anOutGrant1       = grant1;
    anOutMemAddress   = sel_addr[MEM_ADDR_WIDTH-1:0];
    anOutMemWriteData = sel_wdata;
    anOutMemWrite     = any_grant && hit_ram && sel_write;
    anOutMemRead      = any_grant && hit_ram && !sel_write;
  end

  always_comb begin
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    if (any_grant && sel_write && hit_porta) begin
      port_a_d = sel_wdata[7:0];
    end
    if (any_grant && sel_write && hit_portb) begin
      port_b_d = sel_wdata[7:0];
    end
  end

  // Capture everything needed to return the read one cycle later.
  always_comb begin
    rvalid0_d  = any_grant && !sel_write && !win_id;
    rvalid1_d  = any_grant && !sel_write && win_id;
    pend_io_d  = hit_porta ? port_a_q : port_b_q;
    pend_src_d = SRC_ZERO;
    if (hit_io) begin
      pend_src_d = SRC_IO;
    end else if (hit_ram) begin
      pend_src_d = SRC_RAM;
    end
  end

  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      ptr_q      <= 1'b0;
      port_a_q   <= 8'h00;
      port_b_q   <= 8'h00;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      pend_src_q <= SRC_RAM;
      pend_io_q  <= 8'h00;
    end else begin
      ptr_q      <= ptr_d;
      port_a_q   <= port_a_d;
      port_b_q   <= port_b_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      pend_src_q <= pend_src_d;
      pend_io_q  <= pend_io_d;
    end
  end

  always_comb begin
    anOutReadValid0 = rvalid0_q;
    anOutReadValid1 = rvalid1_q;
    anOutPortA      = port_a_q;
    anOutPortB      = port_b_q;
    case (pend_src_q)
      SRC_RAM: anOutReadData = aMemReadData;
      SRC_IO:  anOutReadData = {{(DATA_WIDTH-8){1'b0}}, pend_io_q};
      default: anOutReadData = '0;
    endcase
  end

endmodule
